// File: rtl/frame_uart_tx.sv
// frame_uart_tx
// Streams DEPTH 24-bit words from a registered-output frame RAM over an 8N1 UART
// line. Each word becomes three bytes (MSB byte first, LSB bit first). Pulses done
// once after the last stop bit of the frame.
module frame_uart_tx #(
   parameter int ADDR_BITS = 10,
   parameter int DEPTH     = 1024,
   parameter int CLK_DIV   = 434
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic [ADDR_BITS-1:0] mem_addr,
   input  logic [23:0]          mem_do,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int                   BAUD_W    = $clog2(CLK_DIV);
   localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLK_DIV - 1);
   localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(DEPTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_START = 3'd3,
      ST_DATA  = 3'd4,
      ST_STOP  = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   state_t               state_r, state_next_s;
   logic [BAUD_W-1:0]    baud_r, baud_next_s;
   logic [2:0]           bit_r, bit_next_s;
   logic [1:0]           byte_r, byte_next_s;
   logic [23:0]          word_r, word_next_s;
   logic [ADDR_BITS-1:0] addr_r, addr_next_s;
   logic                 tx_r, tx_next_s;
   logic                 busy_r, busy_next_s;
   logic                 done_r, done_next_s;
   logic                 baud_end_s;
   logic [7:0]           tx_byte_s;

   // Byte lane of a word in transmission order: index 0 is the most significant byte.
   function automatic logic [7:0] sel_byte(input logic [23:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[23:16];
         2'd1:    b = w[15:8];
         2'd2:    b = w[7:0];
         default: b = 8'hFF;
      endcase
      return b;
   endfunction

   assign baud_end_s = (baud_r == BAUD_LAST);

   // State register together with the registered outputs computed from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         baud_r  <= '0;
         bit_r   <= 3'd0;
         byte_r  <= 2'd0;
         word_r  <= 24'd0;
         addr_r  <= '0;
         tx_r    <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         baud_r  <= baud_next_s;
         bit_r   <= bit_next_s;
         byte_r  <= byte_next_s;
         word_r  <= word_next_s;
         addr_r  <= addr_next_s;
         tx_r    <= tx_next_s;
         busy_r  <= busy_next_s;
         done_r  <= done_next_s;
      end
   end

   // Next-state logic: sequencing, baud/bit/byte counters, address and word capture.
   always_comb begin
      state_next_s = state_r;
      baud_next_s  = baud_r;
      bit_next_s   = bit_r;
      byte_next_s  = byte_r;
      word_next_s  = word_r;
      addr_next_s  = addr_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               addr_next_s  = '0;
               baud_next_s  = '0;
               state_next_s = ST_FETCH;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            // RAM registers the address this cycle; data is ready in LOAD.
            state_next_s = ST_LOAD;
         end
         ST_LOAD: begin
            word_next_s  = mem_do;
            byte_next_s  = 2'd0;
            bit_next_s   = 3'd0;
            baud_next_s  = '0;
            state_next_s = ST_START;
         end
         ST_START: begin
            if (baud_end_s) begin
               baud_next_s  = '0;
               bit_next_s   = 3'd0;
               state_next_s = ST_DATA;
            end else begin
               baud_next_s = baud_r + BAUD_W'(1);
            end
         end
         ST_DATA: begin
            if (baud_end_s) begin
               baud_next_s = '0;
               if (bit_r == 3'd7) begin
                  state_next_s = ST_STOP;
               end else begin
                  bit_next_s = bit_r + 3'd1;
               end
            end else begin
               baud_next_s = baud_r + BAUD_W'(1);
            end
         end
         ST_STOP: begin
            if (baud_end_s) begin
               baud_next_s = '0;
               if (byte_r != 2'd2) begin
                  byte_next_s  = byte_r + 2'd1;
                  state_next_s = ST_START;
               end else if (addr_r != ADDR_LAST) begin
                  addr_next_s  = addr_r + ADDR_BITS'(1);
                  state_next_s = ST_FETCH;
               end else begin
                  state_next_s = ST_DONE;
               end
            end else begin
               baud_next_s = baud_r + BAUD_W'(1);
            end
         end
         ST_DONE: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
            baud_next_s  = '0;
         end
      endcase
   end

   // Output logic: line level, busy and done as they must appear once the next state is entered.
   always_comb begin
      tx_byte_s = sel_byte(word_next_s, byte_next_s);
      case (state_next_s)
         ST_START: tx_next_s = 1'b0;
         ST_DATA:  tx_next_s = tx_byte_s[bit_next_s];
         default:  tx_next_s = 1'b1;
      endcase
      busy_next_s = (state_next_s != ST_IDLE);
      done_next_s = (state_next_s == ST_DONE);
   end

   assign mem_addr = addr_r;
   assign tx       = tx_r;
   assign busy     = busy_r;
   assign done     = done_r;

endmodule

// File: tb/tb_frame_uart_tx.sv
// Testbench for frame_uart_tx: two instances (fast baud / depth 4, real baud / depth 1),
// UART receiver monitors and a timing-level reference model feeding scoreboard queues.
module tb_frame_uart_tx;

   localparam int DIV_A = 4;
   localparam int DEP_A = 4;
   localparam int AW_A  = 2;
   localparam int DIV_B = 434;
   localparam int DEP_B = 1;
   localparam int AW_B  = 1;

   logic            clk = 1'b0;
   logic            reset;
   logic            start_a, start_b;
   logic [AW_A-1:0] mem_addr_a;
   logic [AW_B-1:0] mem_addr_b;
   logic [23:0]     mem_do_a, mem_do_b;
   logic            tx_a, tx_b, busy_a, busy_b, done_a, done_b;
   logic [23:0]     mem_a [4];
   logic [23:0]     mem_b [2];

   int cyc   = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int         t;
      logic [7:0] b;
   } rx_t;

   rx_t exp_q0[$];
   rx_t exp_q1[$];
   int  done_q0[$];
   int  done_q1[$];
   bit  act  [2];
   int  t0   [2];
   int  tend [2];

   frame_uart_tx #(.ADDR_BITS(AW_A), .DEPTH(DEP_A), .CLK_DIV(DIV_A)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .mem_addr(mem_addr_a),
      .mem_do(mem_do_a), .tx(tx_a), .busy(busy_a), .done(done_a)
   );

   frame_uart_tx #(.ADDR_BITS(AW_B), .DEPTH(DEP_B), .CLK_DIV(DIV_B)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .mem_addr(mem_addr_b),
      .mem_do(mem_do_b), .tx(tx_b), .busy(busy_b), .done(done_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Registered-output frame memories.
   always @(posedge clk) begin
      mem_do_a <= mem_a[mem_addr_a];
      mem_do_b <= mem_b[mem_addr_b];
   end

   task automatic chk(input string name, input longint got, input longint want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic int div_of(input int i);
      if (i == 0) return DIV_A; else return DIV_B;
   endfunction
   function automatic int dep_of(input int i);
      if (i == 0) return DEP_A; else return DEP_B;
   endfunction
   function automatic int wc(input int i);
      return 2 + 30 * div_of(i);
   endfunction
   function automatic logic tx_of(input int i);
      if (i == 0) return tx_a; else return tx_b;
   endfunction
   function automatic logic busy_of(input int i);
      if (i == 0) return busy_a; else return busy_b;
   endfunction
   function automatic logic done_of(input int i);
      if (i == 0) return done_a; else return done_b;
   endfunction
   function automatic int addr_of(input int i);
      if (i == 0) return int'(mem_addr_a); else return int'(mem_addr_b);
   endfunction
   function automatic logic [23:0] word_of(input int i, input int w);
      if (i == 0) return mem_a[w]; else return mem_b[w];
   endfunction
   function automatic int exp_size(input int i);
      if (i == 0) return exp_q0.size(); else return exp_q1.size();
   endfunction
   function automatic rx_t pop_exp(input int i);
      if (i == 0) return exp_q0.pop_front(); else return exp_q1.pop_front();
   endfunction
   function automatic int done_size(input int i);
      if (i == 0) return done_q0.size(); else return done_q1.size();
   endfunction
   function automatic int pop_done(input int i);
      if (i == 0) return done_q0.pop_front(); else return done_q1.pop_front();
   endfunction

   // Reference model: a start sampled in an idle cycle c opens a frame whose byte start
   // times and done time follow from the frame arithmetic alone.
   task automatic pulse_start(input int i, input int target);
      int  c;
      rx_t e;
      do @(negedge clk); while (cyc < target);
      c = cyc;
      if (i == 0) start_a = 1'b1; else start_b = 1'b1;
      @(posedge clk);
      #1;
      if (i == 0) start_a = 1'b0; else start_b = 1'b0;
      if (!(act[i] && c <= tend[i])) begin
         act[i]  = 1'b1;
         t0[i]   = c + 1;
         tend[i] = t0[i] + dep_of(i) * wc(i);
         for (int w = 0; w < dep_of(i); w++) begin
            for (int j = 0; j < 3; j++) begin
               e.t = t0[i] + w * wc(i) + 2 + j * 10 * div_of(i);
               e.b = 8'((word_of(i, w) >> (16 - 8 * j)) & 24'hFF);
               if (i == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
            end
         end
         if (i == 0) done_q0.push_back(tend[i]); else done_q1.push_back(tend[i]);
      end
   endtask

   task automatic wait_end(input int i);
      do @(negedge clk); while (cyc <= tend[i] + 1);
   endtask

   // UART receiver: samples every cycle of each bit, checks stability, stop bit, byte and timing.
   task automatic rx_loop(input int i);
      logic       prev = 1'b1;
      logic [9:0] bits;
      int         s;
      bit         ok;
      bit         abort;
      rx_t        e;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev = 1'b1;
         end else if (prev && !tx_of(i)) begin
            s     = cyc;
            ok    = 1'b1;
            abort = 1'b0;
            bits  = '0;
            for (int k = 0; k < 10 && !abort; k++) begin
               for (int c = 0; c < div_of(i) && !abort; c++) begin
                  if (k != 0 || c != 0) @(negedge clk);
                  if (reset) abort = 1'b1;
                  else if (c == 0) bits[k] = tx_of(i);
                  else if (tx_of(i) != bits[k]) ok = 1'b0;
               end
            end
            if (!abort) begin
               chk($sformatf("bit_stable[%0d]", i), ok, 1);
               chk($sformatf("stop_bit[%0d]", i), bits[9], 1);
               if (exp_size(i) == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_byte[%0d]: got %02h at cycle %0d, expected none", i, bits[8:1], s);
               end else begin
                  e = pop_exp(i);
                  chk($sformatf("byte[%0d]", i), bits[8:1], e.b);
                  chk($sformatf("byte_time[%0d]", i), s, e.t);
               end
               prev = tx_of(i);
            end else begin
               prev = 1'b1;
            end
         end else begin
            prev = tx_of(i);
         end
      end
   endtask

   // Control monitor: busy window, done pulse timing and address stepping against the model.
   task automatic ctl_loop(input int i);
      bit exp_busy;
      int w;
      forever begin
         @(negedge clk);
         if (!reset) begin
            exp_busy = act[i] && cyc >= t0[i] && cyc <= tend[i];
            chk($sformatf("busy[%0d]", i), busy_of(i), exp_busy);
            if (done_of(i)) begin
               if (done_size(i) == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_done[%0d]: got done at cycle %0d, expected none", i, cyc);
               end else begin
                  chk($sformatf("done_time[%0d]", i), cyc, pop_done(i));
               end
            end
            if (exp_busy) begin
               w = (cyc - t0[i]) / wc(i);
               if (w > dep_of(i) - 1) w = dep_of(i) - 1;
               chk($sformatf("mem_addr[%0d]", i), addr_of(i), w);
            end
         end
      end
   endtask

   initial rx_loop(0);
   initial rx_loop(1);
   initial ctl_loop(0);
   initial ctl_loop(1);

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      foreach (mem_a[k]) mem_a[k] = 24'h0;
      foreach (mem_b[k]) mem_b[k] = 24'h0;
      act[0] = 1'b0;
      act[1] = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_tx_a", tx_a, 1);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_done_a", done_a, 0);
      chk("rst_addr_a", mem_addr_a, 0);
      chk("rst_tx_b", tx_b, 1);
      chk("rst_busy_b", busy_b, 0);
      @(posedge clk);
      #2 reset = 1'b0;

      // Idle without start: outputs hold.
      repeat (10) begin
         @(negedge clk);
         chk("idle_tx_a", tx_a, 1);
         chk("idle_done_a", done_a, 0);
         chk("idle_addr_a", mem_addr_a, 0);
      end

      // Address sequence with fixed contents.
      mem_a[0] = 24'h000001;
      mem_a[1] = 24'h000002;
      mem_a[2] = 24'h000003;
      mem_a[3] = 24'hFFFFFF;
      pulse_start(0, 0);
      wait_end(0);

      // Random frames with ignored starts mid-frame and on DONE, accepted start right after.
      for (int f = 0; f < 6; f++) begin
         foreach (mem_a[k]) mem_a[k] = 24'($urandom);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         pulse_start(0, 0);
         pulse_start(0, t0[0] + $urandom_range(1, wc(0) * DEP_A - 2));
         pulse_start(0, tend[0]);
         if (f % 2 == 1) pulse_start(0, tend[0] + 1);
         wait_end(0);
      end

      // Reset during data bit 1 of byte 1 of word 2, then a clean frame.
      foreach (mem_a[k]) mem_a[k] = 24'($urandom);
      pulse_start(0, 0);
      do @(negedge clk); while (cyc < t0[0] + 2 * wc(0) + 2 + 10 * DIV_A + 2 * DIV_A + 1);
      @(posedge clk);
      #2 reset = 1'b1;
      act[0] = 1'b0;
      act[1] = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
      done_q0.delete();
      done_q1.delete();
      #1;
      chk("midrst_tx_a", tx_a, 1);
      chk("midrst_busy_a", busy_a, 0);
      chk("midrst_done_a", done_a, 0);
      chk("midrst_addr_a", mem_addr_a, 0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      foreach (mem_a[k]) mem_a[k] = 24'($urandom);
      pulse_start(0, 0);
      wait_end(0);

      // Depth-1 frames at real baud rate.
      mem_b[0] = 24'hA5C33C;
      pulse_start(1, 0);
      wait_end(1);
      mem_b[0] = 24'h55AA00;
      pulse_start(1, 0);
      wait_end(1);

      repeat (5) @(negedge clk);
      chk("pending_bytes_a", exp_q0.size(), 0);
      chk("pending_bytes_b", exp_q1.size(), 0);
      chk("pending_done_a", done_q0.size(), 0);
      chk("pending_done_b", done_q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
